// File: rtl/permutation_result_collector.sv
// Folds per-permutation results of one bot back into a single total and queues
// {total, count, sideband} in a show-ahead FIFO with valid/ready and occupancy.
module permutation_result_collector #(
    parameter int RESULT_WIDTH     = 48,
    parameter int EXTRA_DATA_WIDTH = 12,
    parameter int DEPTH_LOG2       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          resultValid,
    input  logic [RESULT_WIDTH-1:0]       resultIn,
    input  logic [2:0]                    selectedPermutationIn,
    input  logic [5:0]                    validPermutesIn,
    input  logic [EXTRA_DATA_WIDTH-1:0]   extraDataIn,
    output logic [RESULT_WIDTH+2:0]       totalOut,
    output logic [2:0]                    permCountOut,
    output logic [EXTRA_DATA_WIDTH-1:0]   extraDataOut,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [DEPTH_LOG2:0]           fifoFullness,
    output logic                          protocolError,
    output logic                          overflowError
);
    localparam int TOTAL_WIDTH = RESULT_WIDTH + 3;
    localparam int ENTRY_WIDTH = TOTAL_WIDTH + 3 + EXTRA_DATA_WIDTH;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                        state_q;
    logic [TOTAL_WIDTH-1:0]        acc_q;
    logic [2:0]                    count_q;
    logic [5:0]                    mask_q;
    logic [5:0]                    remaining_q;
    logic [EXTRA_DATA_WIDTH-1:0]   extra_q;
    logic                          protocol_error_q;
    logic                          overflow_error_q;

    logic [ENTRY_WIDTH-1:0]        mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]         wr_ptr_q;
    logic [DEPTH_LOG2-1:0]         rd_ptr_q;
    logic [DEPTH_LOG2:0]           fill_q;
    logic [DEPTH_LOG2:0]           fill_d;

    logic [5:0]                    perm_bit;
    logic [5:0]                    ref_mask;
    logic [5:0]                    remaining_d;
    logic                          is_first;
    logic                          beat_legal;
    logic                          burst_done;
    logic [TOTAL_WIDTH-1:0]        sum_d;
    logic [2:0]                    count_d;
    logic                          fifo_full;
    logic                          pop;
    logic                          push_ok;
    logic [ENTRY_WIDTH-1:0]        head;

    // Mask bit (5-p) flags permutation p; out-of-range p selects no bit.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_perm_bit
            assign perm_bit[gi] = (selectedPermutationIn == 3'(5 - gi));
        end
    endgenerate

    // Lowest pending permutation is the highest set mask bit; 7 when none.
    function automatic logic [2:0] lowest_perm(input logic [5:0] m);
        logic [2:0] p;
        p = 3'd7;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) begin
                p = 3'(5 - i);
            end
        end
        return p;
    endfunction

    always_comb begin
        is_first    = (state_q == IDLE);
        ref_mask    = is_first ? validPermutesIn : remaining_q;
        beat_legal  = (validPermutesIn != 6'd0)
                   && (selectedPermutationIn == lowest_perm(ref_mask))
                   && (is_first || ((validPermutesIn == mask_q) && (extraDataIn == extra_q)));
        remaining_d = ref_mask & ~perm_bit;
        sum_d       = (is_first ? '0 : acc_q) + TOTAL_WIDTH'(resultIn);
        count_d     = is_first ? 3'd1 : count_q + 3'd1;
        burst_done  = resultValid && beat_legal && (remaining_d == 6'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            acc_q            <= '0;
            count_q          <= '0;
            mask_q           <= '0;
            remaining_q      <= '0;
            extra_q          <= '0;
            protocol_error_q <= 1'b0;
        end else if (resultValid) begin
            if (!beat_legal) begin
                state_q          <= IDLE;
                acc_q            <= '0;
                count_q          <= '0;
                remaining_q      <= '0;
                protocol_error_q <= 1'b1;
            end else if (remaining_d == 6'd0) begin
                state_q     <= IDLE;
                acc_q       <= '0;
                count_q     <= '0;
                remaining_q <= '0;
            end else begin
                state_q     <= BURST;
                acc_q       <= sum_d;
                count_q     <= count_d;
                remaining_q <= remaining_d;
                mask_q      <= validPermutesIn;
                extra_q     <= extraDataIn;
            end
        end
    end

    // A push into a full FIFO is still accepted when the head leaves this cycle.
    always_comb begin
        fifo_full = (fill_q == (DEPTH_LOG2+1)'(DEPTH));
        pop       = (fill_q != '0) && outReady;
        push_ok   = burst_done && (!fifo_full || pop);
        fill_d    = fill_q;
        if (push_ok && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (!push_ok && pop) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fill_q           <= '0;
            overflow_error_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (burst_done && !push_ok) begin
                overflow_error_q <= 1'b1;
            end
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {sum_d, count_d, extraDataIn};
        end
    end

    // Storage is never reset, so the head is masked while the FIFO is empty.
    always_comb begin
        head = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

    assign totalOut      = head[ENTRY_WIDTH-1 -: TOTAL_WIDTH];
    assign permCountOut  = head[EXTRA_DATA_WIDTH +: 3];
    assign extraDataOut  = head[EXTRA_DATA_WIDTH-1:0];
    assign outValid      = (fill_q != '0);
    assign fifoFullness  = fill_q;
    assign protocolError = protocol_error_q;
    assign overflowError = overflow_error_q;

endmodule
